disp_scheduler: RTL

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_sched_pkg.sv | 29 ++
 rtl/disp_scheduler_bin2bcd.sv | 57 +++++
 rtl/disp_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared types and constants for the display scheduler.
//   state_t     - scheduler FSM states
//   ALERT_*     - alert_code encodings
//   FEE_MAX     - largest fee that fits in four decimal digits
//   alert_flags - one-hot {error, fast, med, slow} for an alert code
package disp_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV_FREE,
      CONV_FEE,
      SHOW_FEE,
      SHOW_ALERT
   } state_t;

   localparam logic [1:0]  ALERT_SLOW  = 2'd0;
   localparam logic [1:0]  ALERT_MED   = 2'd1;
   localparam logic [1:0]  ALERT_FAST  = 2'd2;
   localparam logic [1:0]  ALERT_ERROR = 2'd3;

   localparam logic [13:0] FEE_MAX = 14'd9999;

   function automatic logic [3:0] alert_flags(input logic [1:0] code);
      logic [3:0] r;
      r = 4'b0001 << code;
      return r;
   endfunction

endpackage

// File: rtl/disp_scheduler_bin2bcd.sv
// bin2bcd: sequential double-dabble converter, 14-bit binary -> 4 BCD digits.
//   clk, rst_n - clock, async active-low reset
//   start      - load bin and begin; sampled on edge k
//   bin        - binary input (max 9999 for a 4-digit result)
//   bcd        - {thousands, hundreds, tens, ones}; valid when done
//   done       - one-cycle pulse, registered on edge k+14
module bin2bcd (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic        done
);

   logic [13:0] sh_q;
   logic [15:0] bcd_q;
   logic [3:0]  cnt_q;
   logic        run_q;
   logic        done_q;
   logic [15:0] adj;

   // Add 3 to any digit >= 5 before the shift so it carries correctly.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         sh_q   <= bin;
         bcd_q  <= '0;
         cnt_q  <= 4'd14;
         run_q  <= 1'b1;
         done_q <= 1'b0;
      end else if (run_q) begin
         {bcd_q, sh_q} <= {adj[14:0], sh_q, 1'b0};
         cnt_q  <= cnt_q - 4'd1;
         run_q  <= (cnt_q != 4'd1);
         done_q <= (cnt_q == 4'd1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: arbitrates free-count, fee and alert messages onto an
// 8-digit display with text controls.
//   clk, rst_n           - clock, async active-low reset
//   free_cnt             - background free-space count (binary)
//   fee_req/fee_val      - fee request (level) and value; fee_ack pulses on accept
//   alert_req/alert_code - alert request (level) and code; alert_ack pulses on accept
//   D0..D7               - registered digit codes, D0 rightmost
//   text_mode, slow, med, fast, error - text controls
//   busy                 - FSM not in IDLE
module disp_scheduler
   import disp_sched_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  free_cnt,
   input  logic        fee_req,
   input  logic [13:0] fee_val,
   output logic        fee_ack,
   input  logic        alert_req,
   input  logic [1:0]  alert_code,
   output logic        alert_ack,
   output logic [3:0]  D0, D1, D2, D3, D4, D5, D6, D7,
   output logic        text_mode,
   output logic        slow,
   output logic        med,
   output logic        fast,
   output logic        error,
   output logic        busy
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hold_q;
   logic [7:0][3:0]    dig_q;
   logic [3:0]         flags_q;      // {error, fast, med, slow}
   logic               text_q;
   logic               fee_ack_q, alert_ack_q;
   logic [7:0]         last_free_q;
   logic               lf_vld_q;

   logic               conv_start, conv_done;
   logic [13:0]        conv_din;
   logic [15:0]        conv_bcd;
   logic               fee_acc, alert_acc, free_acc;
   logic               wr_free, wr_fee, go_idle;
   logic               hold_end, free_chg;
   logic [13:0]        fee_sat;

   assign hold_end = (hold_q == CNT_W'(HOLD_CYCLES - 1));
   // An invalid last_free counts as a change, forcing a reconversion.
   assign free_chg = !lf_vld_q || (free_cnt != last_free_q);
   assign fee_sat  = (fee_val > FEE_MAX) ? FEE_MAX : fee_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      conv_din   = 14'd0;
      fee_acc    = 1'b0;
      alert_acc  = 1'b0;
      free_acc   = 1'b0;
      wr_free    = 1'b0;
      wr_fee     = 1'b0;
      go_idle    = 1'b0;
      case (state_q)
         IDLE: begin
            if (alert_req) begin
               alert_acc = 1'b1;
               state_d   = SHOW_ALERT;
            end else if (fee_req) begin
               fee_acc    = 1'b1;
               conv_start = 1'b1;
               conv_din   = fee_sat;
               state_d    = CONV_FEE;
            end else if (free_chg) begin
               free_acc   = 1'b1;
               conv_start = 1'b1;
               conv_din   = {6'd0, free_cnt};
               state_d    = CONV_FREE;
            end
         end
         CONV_FREE: if (conv_done) begin
            wr_free = 1'b1;
            state_d = IDLE;
         end
         CONV_FEE: if (conv_done) begin
            wr_fee  = 1'b1;
            state_d = SHOW_FEE;
         end
         SHOW_FEE: begin
            // An alert discards the fee message and restarts the hold.
            if (alert_req) begin
               alert_acc = 1'b1;
               state_d   = SHOW_ALERT;
            end else if (hold_end) begin
               go_idle = 1'b1;
               state_d = IDLE;
            end
         end
         SHOW_ALERT: if (hold_end) begin
            go_idle = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         dig_q       <= '0;
         flags_q     <= '0;
         text_q      <= 1'b0;
         fee_ack_q   <= 1'b0;
         alert_ack_q <= 1'b0;
         last_free_q <= '0;
         lf_vld_q    <= 1'b0;
      end else begin
         fee_ack_q   <= fee_acc;
         alert_ack_q <= alert_acc;
         if (alert_acc || wr_fee)
            hold_q <= '0;
         else if (state_q == SHOW_FEE || state_q == SHOW_ALERT)
            hold_q <= hold_q + 1'b1;
         if (free_acc) begin
            last_free_q <= free_cnt;
            lf_vld_q    <= 1'b1;
         end
         if (go_idle) begin
            lf_vld_q <= 1'b0;
            text_q   <= 1'b0;
            flags_q  <= '0;
         end
         if (alert_acc) begin
            text_q  <= 1'b1;
            flags_q <= alert_flags(alert_code);
         end
         if (wr_free) begin
            dig_q  <= {20'd0, conv_bcd[11:0]};
            text_q <= 1'b0;
         end
         if (wr_fee) begin
            dig_q  <= {16'd0, conv_bcd};
            text_q <= 1'b0;
         end
      end
   end

   bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (conv_din),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   assign {D7, D6, D5, D4, D3, D2, D1, D0} = dig_q;
   assign {error, fast, med, slow} = flags_q;
   assign text_mode = text_q;
   assign fee_ack   = fee_ack_q;
   assign alert_ack = alert_ack_q;
   assign busy      = (state_q != IDLE);

endmodule
